// File: rtl/gshare_update_ctrl_if.sv
// Frontend/PHT bus of the gshare update controller.
// master = frontend + PHT side, slave = the controller.
interface gshare_update_ctrl_if #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned GHR_W  = 4
);
    logic              pred_req;
    logic [ADDR_W-1:0] pred_addr;
    logic              pred_ready;
    logic              pred_valid;
    logic              pred_taken;
    logic [1:0]        pred_tag;
    logic              res_valid;
    logic              res_taken;
    logic              res_ready;
    logic [GHR_W-1:0]  pht_rd_idx;
    logic [1:0]        pht_rd_data;
    logic              pht_wr_en;
    logic [GHR_W-1:0]  pht_wr_idx;
    logic [1:0]        pht_wr_data;
    logic [GHR_W-1:0]  ghr;
    logic [2:0]        inflight;
    logic              flush;

    modport master (
        output pred_req, pred_addr, res_valid, res_taken, pht_rd_data,
        input  pred_ready, pred_valid, pred_taken, pred_tag, res_ready,
               pht_rd_idx, pht_wr_en, pht_wr_idx, pht_wr_data, ghr, inflight, flush
    );

    modport slave (
        input  pred_req, pred_addr, res_valid, res_taken, pht_rd_data,
        output pred_ready, pred_valid, pred_taken, pred_tag, res_ready,
               pht_rd_idx, pht_wr_en, pht_wr_idx, pht_wr_data, ghr, inflight, flush
    );
endinterface

// File: rtl/gshare_update_ctrl.sv
// Gshare predictor controller: speculative history, in-flight branch queue,
// PHT counter update on resolution and history recovery on mispredict.
module gshare_update_ctrl #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned GHR_W  = 4,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    gshare_update_ctrl_if.slave  bus
);
    localparam int unsigned PTR_W = 2;
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {IDLE, UPD_RD, UPD_WR, RECOVER} state_t;

    typedef struct packed {
        logic [GHR_W-1:0] idx;
        logic [GHR_W-1:0] ghr;
        logic             pred;
    } entry_t;

    state_t           state_q, state_d;
    entry_t           queue_q [DEPTH];
    entry_t           queue_d [DEPTH];
    entry_t           head_q, head_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [GHR_W-1:0] ghr_q, ghr_d;
    logic             res_taken_q, res_taken_d;
    logic             pred_valid_q, pred_valid_d, pred_taken_q, pred_taken_d;
    logic [PTR_W-1:0] pred_tag_q, pred_tag_d;
    logic             wr_en_q, wr_en_d, flush_q, flush_d;
    logic [GHR_W-1:0] wr_idx_q, wr_idx_d;
    logic [1:0]       wr_data_q, wr_data_d;
    logic             pred_ready_c, res_ready_c;
    logic [GHR_W-1:0] pred_idx_c, rd_idx_c;
    logic             unused_addr_c;

    assign unused_addr_c = ^bus.pred_addr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Two-bit saturating counter step
    function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic taken);
        if (taken) return (cnt == 2'b11) ? 2'b11 : cnt + 2'd1;
        else       return (cnt == 2'b00) ? 2'b00 : cnt - 2'd1;
    endfunction

    always_comb begin
        state_d      = state_q;
        queue_d      = queue_q;
        head_d       = head_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        inflight_d   = inflight_q;
        ghr_d        = ghr_q;
        res_taken_d  = res_taken_q;
        pred_valid_d = 1'b0;
        pred_taken_d = pred_taken_q;
        pred_tag_d   = pred_tag_q;
        wr_en_d      = 1'b0;
        wr_idx_d     = wr_idx_q;
        wr_data_d    = wr_data_q;
        flush_d      = 1'b0;
        pred_ready_c = 1'b0;
        res_ready_c  = 1'b0;
        pred_idx_c   = bus.pred_addr[GHR_W-1:0] ^ ghr_q;
        rd_idx_c     = pred_idx_c;

        case (state_q)
            IDLE: begin
                res_ready_c  = reset && (inflight_q != '0);
                pred_ready_c = reset && (inflight_q < CNT_W'(DEPTH))
                               && !(bus.res_valid && inflight_q != '0);
                // Resolution wins; pred_ready is already low when it is pending
                if (bus.res_valid && res_ready_c) begin
                    head_d      = queue_q[rd_ptr_q];
                    res_taken_d = bus.res_taken;
                    rd_ptr_d    = ptr_inc(rd_ptr_q);
                    inflight_d  = inflight_q - 1'b1;
                    state_d     = UPD_RD;
                end else if (bus.pred_req && pred_ready_c) begin
                    queue_d[wr_ptr_q] = '{idx: pred_idx_c, ghr: ghr_q, pred: bus.pht_rd_data[1]};
                    ghr_d        = {ghr_q[GHR_W-2:0], bus.pht_rd_data[1]};
                    wr_ptr_d     = ptr_inc(wr_ptr_q);
                    inflight_d   = inflight_q + 1'b1;
                    pred_valid_d = 1'b1;
                    pred_taken_d = bus.pht_rd_data[1];
                    pred_tag_d   = wr_ptr_q;
                end
            end
            UPD_RD: begin
                rd_idx_c  = head_q.idx;
                wr_en_d   = 1'b1;
                wr_idx_d  = head_q.idx;
                wr_data_d = sat_step(bus.pht_rd_data, res_taken_q);
                state_d   = UPD_WR;
            end
            UPD_WR: begin
                if (res_taken_q != head_q.pred) begin
                    flush_d = 1'b1;
                    state_d = RECOVER;
                end else begin
                    state_d = IDLE;
                end
            end
            RECOVER: begin
                ghr_d = {head_q.ghr[GHR_W-2:0], res_taken_q};
                for (int i = 0; i < int'(DEPTH); i++) queue_d[i] = '0;
                wr_ptr_d   = '0;
                rd_ptr_d   = '0;
                inflight_d = '0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) queue_q[i] <= '0;
            head_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            inflight_q   <= '0;
            ghr_q        <= '0;
            res_taken_q  <= 1'b0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_tag_q   <= '0;
            wr_en_q      <= 1'b0;
            wr_idx_q     <= '0;
            wr_data_q    <= '0;
            flush_q      <= 1'b0;
        end else begin
            queue_q      <= queue_d;
            head_q       <= head_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            inflight_q   <= inflight_d;
            ghr_q        <= ghr_d;
            res_taken_q  <= res_taken_d;
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            pred_tag_q   <= pred_tag_d;
            wr_en_q      <= wr_en_d;
            wr_idx_q     <= wr_idx_d;
            wr_data_q    <= wr_data_d;
            flush_q      <= flush_d;
        end
    end

    assign bus.pred_ready  = pred_ready_c;
    assign bus.res_ready   = res_ready_c;
    assign bus.pht_rd_idx  = rd_idx_c;
    assign bus.pred_valid  = pred_valid_q;
    assign bus.pred_taken  = pred_taken_q;
    assign bus.pred_tag    = pred_tag_q;
    assign bus.pht_wr_en   = wr_en_q;
    assign bus.pht_wr_idx  = wr_idx_q;
    assign bus.pht_wr_data = wr_data_q;
    assign bus.ghr         = ghr_q;
    assign bus.inflight    = inflight_q;
    assign bus.flush       = flush_q;
endmodule

// File: tb/tb_gshare_update_ctrl.sv
// Directed bench for gshare_update_ctrl; the PHT read data is driven per vector.
module tb_gshare_update_ctrl;
    logic clk;
    logic reset;
    int   n_total;
    int   n_bad;

    gshare_update_ctrl_if #(.ADDR_W(11), .GHR_W(4)) bus ();

    gshare_update_ctrl #(.ADDR_W(11), .GHR_W(4), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One accepted prediction: drive in IDLE, check the latency-1 result
    task automatic do_pred(input logic [10:0] addr, input logic [1:0] cnt,
                           input int exp_idx, input int exp_taken, input int exp_tag,
                           input int exp_ghr, input int exp_inf);
        @(negedge clk);
        bus.pred_req    = 1'b1;
        bus.pred_addr   = addr;
        bus.pht_rd_data = cnt;
        #1;
        check("pred_idx", 32'(bus.pht_rd_idx), exp_idx);
        check("pred_ready", 32'(bus.pred_ready), 1);
        @(posedge clk);
        #1;
        bus.pred_req = 1'b0;
        check("pred_valid", 32'(bus.pred_valid), 1);
        check("pred_taken", 32'(bus.pred_taken), exp_taken);
        check("pred_tag", 32'(bus.pred_tag), exp_tag);
        check("pred_ghr", 32'(bus.ghr), exp_ghr);
        check("pred_inflight", 32'(bus.inflight), exp_inf);
    endtask

    // One resolution through UPD_RD/UPD_WR and optionally RECOVER
    task automatic do_res(input logic taken, input logic with_pred, input logic [1:0] cnt,
                          input int exp_idx, input int exp_data, input int exp_flush,
                          input int exp_ghr, input int exp_inf);
        @(negedge clk);
        bus.res_valid = 1'b1;
        bus.res_taken = taken;
        bus.pred_req  = with_pred;
        #1;
        check("res_ready", 32'(bus.res_ready), 1);
        check("idle_pred_ready", 32'(bus.pred_ready), 0);
        @(posedge clk);
        #1;
        bus.res_valid = 1'b0;
        bus.pred_req  = 1'b0;
        @(negedge clk);
        bus.pht_rd_data = cnt;
        #1;
        check("rd_idx", 32'(bus.pht_rd_idx), exp_idx);
        check("rd_wr_en", 32'(bus.pht_wr_en), 0);
        check("rd_res_ready", 32'(bus.res_ready), 0);
        check("rd_pred_ready", 32'(bus.pred_ready), 0);
        check("rd_pred_valid", 32'(bus.pred_valid), 0);
        @(negedge clk);
        check("wr_en", 32'(bus.pht_wr_en), 1);
        check("wr_idx", 32'(bus.pht_wr_idx), exp_idx);
        check("wr_data", 32'(bus.pht_wr_data), exp_data);
        check("wr_flush", 32'(bus.flush), 0);
        @(negedge clk);
        if (exp_flush != 0) begin
            check("rec_flush", 32'(bus.flush), 1);
            check("rec_wr_en", 32'(bus.pht_wr_en), 0);
            check("rec_pred_ready", 32'(bus.pred_ready), 0);
            @(negedge clk);
        end
        check("end_flush", 32'(bus.flush), 0);
        check("end_wr_en", 32'(bus.pht_wr_en), 0);
        check("end_ghr", 32'(bus.ghr), exp_ghr);
        check("end_inflight", 32'(bus.inflight), exp_inf);
        check("end_pred_ready", 32'(bus.pred_ready), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_total         = 0;
        n_bad           = 0;
        reset           = 1'b0;
        bus.pred_req    = 1'b0;
        bus.pred_addr   = '0;
        bus.res_valid   = 1'b0;
        bus.res_taken   = 1'b0;
        bus.pht_rd_data = 2'b00;
        repeat (2) @(negedge clk);
        check("rst_ghr", 32'(bus.ghr), 0);
        check("rst_inflight", 32'(bus.inflight), 0);
        check("rst_pred_ready", 32'(bus.pred_ready), 0);
        check("rst_res_ready", 32'(bus.res_ready), 0);
        check("rst_pred_valid", 32'(bus.pred_valid), 0);
        check("rst_wr_en", 32'(bus.pht_wr_en), 0);
        check("rst_flush", 32'(bus.flush), 0);
        reset = 1'b1;

        // First prediction and its correct resolution, with a colliding pred_req
        do_pred(11'h005, 2'b10, 5, 1, 0, 1, 1);
        do_res(1'b1, 1'b1, 2'b10, 5, 3, 0, 1, 0);

        // Strong-taken counter stays saturated
        do_pred(11'h004, 2'b11, 5, 1, 1, 3, 1);
        do_res(1'b1, 1'b0, 2'b11, 5, 3, 0, 3, 0);

        // Fill the queue; tags wrap from 3 to 0
        do_pred(11'h000, 2'b10, 3, 1, 2, 7, 1);
        do_pred(11'h000, 2'b01, 7, 0, 3, 14, 2);
        do_pred(11'h000, 2'b10, 14, 1, 0, 13, 3);
        do_pred(11'h7F3, 2'b11, 14, 1, 1, 11, 4);

        // Fifth request against a full queue
        @(negedge clk);
        bus.pred_req    = 1'b1;
        bus.pred_addr   = '0;
        bus.pht_rd_data = 2'b10;
        #1;
        check("full_pred_ready", 32'(bus.pred_ready), 0);
        @(posedge clk);
        #1;
        bus.pred_req = 1'b0;
        check("full_pred_valid", 32'(bus.pred_valid), 0);
        check("full_ghr", 32'(bus.ghr), 11);
        check("full_inflight", 32'(bus.inflight), 4);

        // Head (idx 3, snapshot 0011, predicted taken) resolves not-taken
        do_res(1'b0, 1'b0, 2'b10, 3, 1, 1, 6, 0);

        // Strong-not-taken counter stays saturated; queue restarted at slot 0
        do_pred(11'h000, 2'b00, 6, 0, 0, 12, 1);
        do_res(1'b0, 1'b0, 2'b00, 6, 0, 0, 12, 0);

        // Reset asserted while in UPD_RD abandons the write
        do_pred(11'h000, 2'b10, 12, 1, 1, 9, 1);
        @(negedge clk);
        bus.res_valid = 1'b1;
        bus.res_taken = 1'b1;
        @(posedge clk);
        #1;
        bus.res_valid = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        check("arst_wr_en", 32'(bus.pht_wr_en), 0);
        check("arst_ghr", 32'(bus.ghr), 0);
        check("arst_inflight", 32'(bus.inflight), 0);
        check("arst_pred_tag", 32'(bus.pred_tag), 0);
        check("arst_pred_taken", 32'(bus.pred_taken), 0);
        check("arst_pred_ready", 32'(bus.pred_ready), 0);
        @(posedge clk);
        #1;
        check("arst_wr_en_hold", 32'(bus.pht_wr_en), 0);
        check("arst_flush_hold", 32'(bus.flush), 0);
        @(negedge clk);
        reset = 1'b1;

        // Mispredict from an all-zero snapshot
        do_pred(11'h005, 2'b10, 5, 1, 0, 1, 1);
        do_res(1'b0, 1'b0, 2'b10, 5, 1, 1, 0, 0);

        // Resolution against an empty queue is ignored
        @(negedge clk);
        bus.res_valid = 1'b1;
        bus.res_taken = 1'b1;
        #1;
        check("empty_res_ready", 32'(bus.res_ready), 0);
        check("empty_pred_ready", 32'(bus.pred_ready), 1);
        @(negedge clk);
        bus.res_valid = 1'b0;
        #1;
        check("empty_wr_en", 32'(bus.pht_wr_en), 0);
        check("empty_inflight", 32'(bus.inflight), 0);
        check("empty_idle", 32'(bus.pred_ready), 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
